kernel_dispatcher: RTL
======================

Name: kernel_dispatcher

Overview:
- Sequences descriptor-driven jobs from job_manager onto KERNEL_NUM parallel kernels.
- Consumes job_manager's job_start pulse and its user/system registers.
- Picks an idle kernel round-robin, issues a one-hot start, and tracks per-kernel busy state.
- Drives job_manager's new_job (fetch the next descriptor) and job_done (kernel completion) inputs. Closes the session once the last descriptor's kernels have all finished.

Parameters:
- KERNEL_NUM, 8, number of kernels served (2..16)
- REG_WIDTH, 512, width of user/system register buses

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- dispatch_start  in  1  session start pulse, issued alongside job_manager's manager_start
- job_start  in  1  descriptor valid, one-cycle pulse from job_manager
- desc_last  in  1  sampled with job_start; descriptor's next pointer is zero
- user_register  in  REG_WIDTH  descriptor user data
- system_register  in  REG_WIDTH  descriptor system data
- new_job  out  1  pulse: job_manager fetches next descriptor
- job_done  out  1  pulse: at least one kernel completed this cycle
- kernel_start  out  KERNEL_NUM  one-hot start pulse
- kernel_user_reg  out  REG_WIDTH  latched user data, shared by all kernels
- kernel_sys_reg  out  REG_WIDTH  latched system data, shared by all kernels
- kernel_done  in  KERNEL_NUM  per-kernel completion pulses
- kernel_busy  out  KERNEL_NUM  busy bitmap
- session_done  out  1  pulse: session complete
- spurious_done  out  1  sticky: kernel_done seen on an idle kernel
- dispatch_count  out  32  jobs issued this session
- stall_cycles  out  32  see Optional Feature

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE and rr_ptr is 0.
  - Reset mid-operation aborts immediately: busy is cleared and no pulses are emitted.
- States and transitions:
  - IDLE: on dispatch_start, clear dispatch_count, stall_cycles and spurious_done, then go to FETCH. dispatch_start is ignored in every other state.
  - FETCH: wait for job_start. When it arrives, latch user_register→kernel_user_reg, system_register→kernel_sys_reg and desc_last→last_q, then go to SELECT. A job_start seen in any other state is ignored.
  - SELECT: scan the registered ~kernel_busy starting at rr_ptr, wrapping modulo KERNEL_NUM. The first idle index becomes sel and the FSM goes to ISSUE. If no kernel is idle, stay in SELECT.
  - ISSUE (one cycle):
    - kernel_start = 1<<sel and kernel_busy[sel] is set.
    - rr_ptr = (sel+1) mod KERNEL_NUM; dispatch_count increments.
    - If last_q: go to DRAIN. Otherwise new_job=1 this cycle and go to FETCH.
  - DRAIN: when kernel_busy==0, go to DONE.
  - DONE: session_done=1 for one cycle, then go to IDLE.
- Latency: job_start sampled in cycle t produces kernel_start in cycle t+2 if a kernel is idle.
- Latched kernel_user_reg and kernel_sys_reg are held until the next job_start in FETCH.
- kernel_done handling:
  - Each asserted bit with busy=1 clears that busy bit next cycle.
  - job_done is a single-cycle pulse, registered one cycle after any valid done. It is a single pulse even when several done bits are asserted together.
  - A done bit on an idle kernel sets spurious_done; busy is unchanged and no job_done is generated.
- Simultaneous events:
  - kernel_done[j] in the same cycle as an ISSUE to kernel i≠j: both take effect.
  - A kernel freed in cycle t becomes selectable in SELECT from cycle t+1.
- Arithmetic: dispatch_count wraps modulo 2^32.

Optional Feature:
- Macro KERNEL_DISPATCHER_STALL_CNT_EN.
- Defined: stall_cycles increments every cycle spent in SELECT with kernel_busy all ones. It saturates at 32'hFFFFFFFF and clears on dispatch_start.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Reset → all outputs 0, kernel_busy=8'h00; job_start pulses in IDLE → no kernel_start.
- Single job: dispatch_start, then job_start with desc_last=1 at t → kernel_start=8'h01 at t+2, no new_job. Then kernel_done[0] → job_done pulse, then session_done, and dispatch_count=1.
- Nine jobs (desc_last=0 on the first eight, no dones):
  - First eight go to kernels 0..7 in order, each ISSUE with new_job=1.
  - Ninth stalls in SELECT; with the macro defined, stall_cycles counts the stall.
  - kernel_done[3] → ninth job starts kernel 3 (kernel_start=8'h08).
- Wrap and simultaneity: after kernel 7 is issued (rr_ptr=0), assert kernel_done[0] and kernel_done[5] together → exactly one job_done pulse. Busy bits 0 and 5 clear, and the next job goes to kernel 0.
- kernel_done[6] while kernel 6 is idle → spurious_done=1 sticky, no job_done, kernel_busy unchanged.
- rst_n asserted while four kernels are busy → kernel_busy=0 and state IDLE at once. Then dispatch_start and job_start → kernel 0 is selected again.

Source files
------------

// File: rtl/kernel_dispatcher.sv
// Round-robin dispatcher from job_manager descriptors onto KERNEL_NUM parallel kernels.
// Optional stall counter: define KERNEL_DISPATCHER_STALL_CNT_EN.
module kernel_dispatcher #(
  parameter int unsigned KERNEL_NUM = 8,
  parameter int unsigned REG_WIDTH  = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dispatch_start,
  input  logic                  job_start,
  input  logic                  desc_last,
  input  logic [REG_WIDTH-1:0]  user_register,
  input  logic [REG_WIDTH-1:0]  system_register,
  output logic                  new_job,
  output logic                  job_done,
  output logic [KERNEL_NUM-1:0] kernel_start,
  output logic [REG_WIDTH-1:0]  kernel_user_reg,
  output logic [REG_WIDTH-1:0]  kernel_sys_reg,
  input  logic [KERNEL_NUM-1:0] kernel_done,
  output logic [KERNEL_NUM-1:0] kernel_busy,
  output logic                  session_done,
  output logic                  spurious_done,
  output logic [31:0]           dispatch_count,
  output logic [31:0]           stall_cycles
);

  localparam int unsigned PtrW = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
  localparam logic [KERNEL_NUM-1:0] OneHot0 = KERNEL_NUM'(1);

  typedef enum logic [2:0] {StIdle, StFetch, StSelect, StIssue, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]       sel_q, sel_d;
  logic                  last_q, last_d;
  logic [KERNEL_NUM-1:0] busy_q, busy_d;
  logic [REG_WIDTH-1:0]  user_q, user_d;
  logic [REG_WIDTH-1:0]  sys_q, sys_d;
  logic                  job_done_q, job_done_d;
  logic                  spurious_q, spurious_d;
  logic [31:0]           count_q, count_d;

  logic [KERNEL_NUM-1:0] done_valid;
  logic                  found;
  logic [PtrW-1:0]       sel_scan;
  logic [PtrW-1:0]       idx_w;
  int unsigned           idx;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    sel_d        = sel_q;
    last_d       = last_q;
    user_d       = user_q;
    sys_d        = sys_q;
    count_d      = count_q;
    new_job      = 1'b0;
    kernel_start = '0;
    session_done = 1'b0;

    // Only dones on busy kernels count; the rest are flagged as spurious.
    done_valid = kernel_done & busy_q;
    busy_d     = busy_q & ~done_valid;
    job_done_d = |done_valid;
    spurious_d = spurious_q | (|(kernel_done & ~busy_q));

    found    = 1'b0;
    sel_scan = sel_q;
    idx      = 0;
    idx_w    = '0;
    for (int unsigned i = 0; i < KERNEL_NUM; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= KERNEL_NUM) idx = idx - KERNEL_NUM;
      idx_w = idx[PtrW-1:0];
      if (!found && !busy_q[idx_w]) begin
        found    = 1'b1;
        sel_scan = idx_w;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (dispatch_start) begin
          count_d    = '0;
          spurious_d = 1'b0;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        if (job_start) begin
          user_d  = user_register;
          sys_d   = system_register;
          last_d  = desc_last;
          state_d = StSelect;
        end
      end
      StSelect: begin
        if (found) begin
          sel_d   = sel_scan;
          state_d = StIssue;
        end
      end
      StIssue: begin
        kernel_start  = OneHot0 << sel_q;
        busy_d[sel_q] = 1'b1;
        rr_ptr_d      = (sel_q == PtrW'(KERNEL_NUM - 1)) ? '0 : sel_q + 1'b1;
        count_d       = count_q + 32'd1;
        if (last_q) begin
          state_d = StDrain;
        end else begin
          new_job = 1'b1;
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (busy_q == '0) state_d = StDone;
      end
      StDone: begin
        session_done = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      sel_q      <= '0;
      last_q     <= 1'b0;
      busy_q     <= '0;
      user_q     <= '0;
      sys_q      <= '0;
      job_done_q <= 1'b0;
      spurious_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      user_q     <= user_d;
      sys_q      <= sys_d;
      job_done_q <= job_done_d;
      spurious_q <= spurious_d;
      count_q    <= count_d;
    end
  end

`ifdef KERNEL_DISPATCHER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Counts SELECT cycles spent waiting with every kernel busy; saturates.
  always_comb begin
    stall_d = stall_q;
    if (state_q == StIdle && dispatch_start) begin
      stall_d = '0;
    end else if (state_q == StSelect && (&busy_q) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign job_done        = job_done_q;
  assign kernel_busy     = busy_q;
  assign kernel_user_reg = user_q;
  assign kernel_sys_reg  = sys_q;
  assign spurious_done   = spurious_q;
  assign dispatch_count  = count_q;

endmodule
